// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like port between the inst and data masters and routes each in-order response back to its requester.
// Optional macro SRAM_ARB_RR_EN selects round-robin arbitration instead of fixed data-over-inst priority.
module sram_port_arbiter #(
  parameter int OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int PW = $clog2(OUTSTANDING);
  localparam int CW = PW + 1;

  logic [OUTSTANDING-1:0] id_fifo;
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [CW-1:0]          count;
  logic                   lock;
  logic                   owner;
  logic                   winner;
  logic                   winner_req;
  logic                   full;
  logic                   accept;
  logic                   pop;
  logic                   head_id;
`ifdef SRAM_ARB_RR_EN
  logic                   rr_last;
`endif

  // Master id: 0 = inst, 1 = data. A locked grant overrides arbitration.
  always_comb begin
    winner = owner;
    if (!lock) begin
`ifdef SRAM_ARB_RR_EN
      if (data_sram_req && inst_sram_req) winner = ~rr_last;
      else                                winner = data_sram_req;
`else
      winner = data_sram_req;
`endif
    end
  end

  assign full       = (count == CW'(OUTSTANDING));
  assign winner_req = winner ? data_sram_req : inst_sram_req;
  assign mem_req    = resetn & winner_req & ~full;

  assign mem_wr    = winner ? data_sram_wr    : inst_sram_wr;
  assign mem_size  = winner ? data_sram_size  : inst_sram_size;
  assign mem_wstrb = winner ? data_sram_wstrb : inst_sram_wstrb;
  assign mem_addr  = winner ? data_sram_addr  : inst_sram_addr;
  assign mem_wdata = winner ? data_sram_wdata : inst_sram_wdata;

  assign accept            = mem_req & mem_addr_ok;
  assign inst_sram_addr_ok = accept & ~winner;
  assign data_sram_addr_ok = accept & winner;

  // Responses with an empty FIFO (stray or pre-reset) are dropped here.
  assign pop               = resetn & mem_data_ok & (count != '0);
  assign head_id           = id_fifo[rd_ptr];
  assign inst_sram_data_ok = pop & ~head_id;
  assign data_sram_data_ok = pop & head_id;
  assign inst_sram_rdata   = mem_rdata;
  assign data_sram_rdata   = mem_rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      lock    <= 1'b0;
      owner   <= 1'b0;
`ifdef SRAM_ARB_RR_EN
      rr_last <= 1'b0;
`endif
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      lock <= mem_req & ~mem_addr_ok;
      if (mem_req) owner <= winner;
`ifdef SRAM_ARB_RR_EN
      if (accept) rr_last <= winner;
`endif
    end
  end

  // FIFO payload needs no reset: entries are only read below count.
  always_ff @(posedge clk) begin
    if (accept) id_fifo[wr_ptr] <= winner;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: queue-based reference model checked every cycle, directed scenarios, then random traffic.
module tb_sram_port_arbiter;

  localparam int OUT = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_req, i_wr, d_req, d_wr;
  logic [1:0]  i_size, d_size;
  logic [3:0]  i_wstrb, d_wstrb;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
  logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int cmp_n  = 0;
  int fail_n = 0;

  // reference model state
  bit m_q[$];
  bit m_lock, m_owner, m_rr;
  bit m_iacc, m_dacc;

  // DUT outputs captured at the last checked negedge
  logic        s_mreq, s_iaok, s_daok, s_idok, s_ddok;
  logic [31:0] s_maddr, s_rdata;

  always #5 clk = ~clk;

  sram_port_arbiter #(.OUTSTANDING(OUT)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(i_req), .inst_sram_wr(i_wr), .inst_sram_size(i_size),
    .inst_sram_wstrb(i_wstrb), .inst_sram_addr(i_addr), .inst_sram_wdata(i_wdata),
    .inst_sram_addr_ok(i_addr_ok), .inst_sram_data_ok(i_data_ok), .inst_sram_rdata(i_rdata),
    .data_sram_req(d_req), .data_sram_wr(d_wr), .data_sram_size(d_size),
    .data_sram_wstrb(d_wstrb), .data_sram_addr(d_addr), .data_sram_wdata(d_wdata),
    .data_sram_addr_ok(d_addr_ok), .data_sram_data_ok(d_data_ok), .data_sram_rdata(d_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      fail_n++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: check outputs at negedge against the model, advance the model, return 1 after posedge.
  task automatic go();
    bit w, wreq, ereq, eacc, epop, head;
    @(negedge clk);
    if (m_lock) w = m_owner;
`ifdef SRAM_ARB_RR_EN
    else if (d_req && i_req) w = ~m_rr;
`endif
    else w = d_req;
    wreq = w ? d_req : i_req;
    ereq = resetn && wreq && (m_q.size() < OUT);
    eacc = ereq && mem_addr_ok;
    epop = resetn && mem_data_ok && (m_q.size() != 0);
    head = epop ? m_q[0] : 1'b0;
    s_mreq = mem_req; s_iaok = i_addr_ok; s_daok = d_addr_ok;
    s_idok = i_data_ok; s_ddok = d_data_ok; s_maddr = mem_addr; s_rdata = i_rdata;
    chk("mem_req", {31'd0, mem_req}, {31'd0, ereq});
    if (ereq) begin
      chk("mem_addr", mem_addr, w ? d_addr : i_addr);
      chk("mem_wdata", mem_wdata, w ? d_wdata : i_wdata);
      chk("mem_ctl", {25'd0, mem_wr, mem_size, mem_wstrb},
          w ? {25'd0, d_wr, d_size, d_wstrb} : {25'd0, i_wr, i_size, i_wstrb});
    end
    chk("inst_addr_ok", {31'd0, i_addr_ok}, {31'd0, eacc && !w});
    chk("data_addr_ok", {31'd0, d_addr_ok}, {31'd0, eacc && w});
    chk("inst_data_ok", {31'd0, i_data_ok}, {31'd0, epop && !head});
    chk("data_data_ok", {31'd0, d_data_ok}, {31'd0, epop && head});
    if (epop) begin
      chk("inst_rdata", i_rdata, mem_rdata);
      chk("data_rdata", d_rdata, mem_rdata);
    end
    m_iacc = eacc && !w;
    m_dacc = eacc && w;
    if (!resetn) begin
      m_q.delete(); m_lock = 0; m_owner = 0; m_rr = 0;
    end else begin
      if (epop) void'(m_q.pop_front());
      if (eacc) m_q.push_back(w);
      m_lock = ereq && !mem_addr_ok;
      if (ereq) m_owner = w;
      if (eacc) m_rr = w;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      mem_data_ok = 1; mem_rdata = $urandom; go();
    end
    mem_data_ok = 0;
  endtask

  bit i_pend, d_pend;

  initial begin
    resetn = 0; i_req = 0; i_wr = 0; i_size = 2; i_wstrb = 4'hf; i_addr = 0; i_wdata = 0;
    d_req = 0; d_wr = 0; d_size = 2; d_wstrb = 4'hf; d_addr = 0; d_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    go();
    chk("reset_mem_req", {31'd0, s_mreq}, 32'd0);
    go();
    resetn = 1;

    // inst read accepted immediately, response two cycles later
    i_req = 1; i_addr = 32'h1c000000; mem_addr_ok = 1;
    go();
    chk("t1_addr_ok", {31'd0, s_iaok}, 32'd1);
    chk("t1_addr", s_maddr, 32'h1c000000);
    i_req = 0; mem_addr_ok = 0;
    go();
    mem_data_ok = 1; mem_rdata = 32'h02800c0c;
    go();
    chk("t1_data_ok", {31'd0, s_idok}, 32'd1);
    chk("t1_rdata", s_rdata, 32'h02800c0c);
    chk("t1_no_dok", {31'd0, s_ddok}, 32'd0);
    mem_data_ok = 0;

    // simultaneous requests: data first, responses routed in order
    i_req = 1; i_addr = 32'h1000; d_req = 1; d_addr = 32'h2000; mem_addr_ok = 1;
    go();
    chk("t2_data_first", {31'd0, s_daok}, 32'd1);
    chk("t2_inst_wait", {31'd0, s_iaok}, 32'd0);
    d_req = 0;
    go();
    chk("t2_inst_next", {31'd0, s_iaok}, 32'd1);
    i_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hAAAA;
    go();
    chk("t2_ret_data", {31'd0, s_ddok}, 32'd1);
    mem_rdata = 32'hBBBB;
    go();
    chk("t2_ret_inst", {31'd0, s_idok}, 32'd1);
    mem_data_ok = 0;

    // lock holds the inst grant while data requests
    i_req = 1; i_addr = 32'h3000; mem_addr_ok = 0;
    go();
    chk("t3_addr_c0", s_maddr, 32'h3000);
    d_req = 1; d_addr = 32'h4000;
    go();
    chk("t3_addr_c1", s_maddr, 32'h3000);
    go();
    chk("t3_addr_c2", s_maddr, 32'h3000);
    mem_addr_ok = 1;
    go();
    chk("t3_addr_c3", s_maddr, 32'h3000);
    chk("t3_inst_acc", {31'd0, s_iaok}, 32'd1);
    chk("t3_data_wait", {31'd0, s_daok}, 32'd0);
    i_req = 0;
    go();
    chk("t3_data_acc", {31'd0, s_daok}, 32'd1);
    d_req = 0; mem_addr_ok = 0;
    drain(2);

    // FIFO full blocks the fifth request, including on the popping cycle
    d_req = 1; mem_addr_ok = 1;
    for (int k = 0; k < 4; k++) begin
      d_addr = 32'h100 + 32'(4 * k);
      go();
      chk("t4_acc", {31'd0, s_daok}, 32'd1);
    end
    d_addr = 32'h110;
    go();
    chk("t4_full", {31'd0, s_mreq}, 32'd0);
    mem_data_ok = 1; mem_rdata = 32'h55;
    go();
    chk("t4_full_pop", {31'd0, s_mreq}, 32'd0);
    chk("t4_pop_dok", {31'd0, s_ddok}, 32'd1);
    mem_data_ok = 0;
    go();
    chk("t4_fifth_acc", {31'd0, s_daok}, 32'd1);
    chk("t4_fifth_addr", s_maddr, 32'h110);
    d_req = 0; mem_addr_ok = 0;
    drain(4);

    // stray response, then reset with requests in flight
    mem_data_ok = 1;
    go();
    chk("t5_stray_i", {31'd0, s_idok}, 32'd0);
    chk("t5_stray_d", {31'd0, s_ddok}, 32'd0);
    mem_data_ok = 0; i_req = 1; mem_addr_ok = 1;
    go(); go();
    resetn = 0;
    go();
    chk("t5_rst_req", {31'd0, s_mreq}, 32'd0);
    resetn = 1; i_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    go();
    chk("t5_drop1", {31'd0, s_idok}, 32'd0);
    go();
    chk("t5_drop2", {31'd0, s_idok}, 32'd0);
    mem_data_ok = 0;

`ifdef SRAM_ARB_RR_EN
    // round robin alternates under continuous contention
    i_req = 1; d_req = 1; mem_addr_ok = 1;
    for (int k = 0; k < 4; k++) begin
      go();
      chk("t6_rr", {31'd0, s_daok}, (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    i_req = 0; d_req = 0; mem_addr_ok = 0;
    drain(4);
`endif

    // random traffic with protocol-abiding masters
    i_pend = 0; d_pend = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        resetn = 0; i_pend = 0; d_pend = 0;
      end else begin
        resetn = 1;
      end
      if (!i_pend && resetn && $urandom_range(0, 2) == 0) begin
        i_pend = 1; i_wr = 1'($urandom); i_size = 2'($urandom); i_wstrb = 4'($urandom);
        i_addr = $urandom; i_wdata = $urandom;
      end
      if (!d_pend && resetn && $urandom_range(0, 2) == 0) begin
        d_pend = 1; d_wr = 1'($urandom); d_size = 2'($urandom); d_wstrb = 4'($urandom);
        d_addr = $urandom; d_wdata = $urandom;
      end
      i_req = i_pend; d_req = d_pend;
      mem_addr_ok = 1'($urandom);
      mem_data_ok = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      go();
      if (m_iacc) i_pend = 0;
      if (m_dacc) d_pend = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule
